toggle_handshake_responder: RTL

TOGGLE_HANDSHAKE_RESPONDER -- requirements
Module: toggle_handshake_responder

---
 rtl/toggle_handshake_responder.sv | 95 +++++++++
 1 files changed

// File: rtl/toggle_handshake_responder.sv
// Toggle-based request/acknowledge responder: synchronizes an asynchronous request
// toggle, captures the payload, and acknowledges by toggling ack_t after the consumer takes it.
module toggle_handshake_responder #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          req_t,
    input  logic [DW-1:0] data_in,
    input  logic          rdy,
    output logic [DW-1:0] data_out,
    output logic          valid,
    output logic          ack_t,
    output logic [7:0]    toggle_cnt,
    output logic          err
);

    typedef enum logic {
        IDLE,
        VALID
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   req_ref_q, req_ref_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   ack_q, ack_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   tog;

    assign req_s = sync_q[SYNC_STAGES-1];
    assign tog   = req_s ^ req_ref_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            req_ref_q <= 1'b0;
            data_q    <= '0;
            ack_q     <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], req_t};
            state_q   <= state_d;
            req_ref_q <= req_ref_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ref_d = req_ref_q;
        data_d    = data_q;
        ack_d     = ack_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (en && tog) begin
                    data_d    = data_in;
                    req_ref_d = req_s;
                    state_d   = VALID;
                end
            end
            VALID: begin
                // A new toggle while busy is dropped and flagged; completion still proceeds.
                if (tog) begin
                    err_d     = 1'b1;
                    req_ref_d = req_s;
                end
                if (rdy) begin
                    state_d = IDLE;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out   = data_q;
    assign valid      = (state_q == VALID);
    assign ack_t      = ack_q;
    assign toggle_cnt = cnt_q;
    assign err        = err_q;

endmodule
